// File: rtl/pool2_maxpool.sv
// 2x2 stride-2 max-pooling stage for the layer-2 feature-map stream.
// Raster-order pixels of channel_num signed lanes go in; one pooled pixel
// per 2x2 window comes out with a one-cycle start pulse. A single half-width
// line of partial maxima (top-row pairs) is kept in registers.
module pool2_maxpool #(
  parameter int bits         = 16,
  parameter int bits_shift   = 4,
  parameter int channel_num  = 8,
  parameter int in_length    = 44,
  parameter int in_length_2  = 6,
  parameter int in_height    = 122,
  parameter int in_height_2  = 7,
  parameter int out_length   = 22,
  parameter int out_length_2 = 5
) (
  input  logic                                clk_in,
  input  logic                                rst_n,
  input  logic                                data_valid,
  input  logic [(channel_num<<bits_shift)-1:0] data_in,
  output logic [(channel_num<<bits_shift)-1:0] data_out,
  output logic                                start,
  output logic                                frame_done
);

  localparam int BUS_W = channel_num << bits_shift;
  localparam logic [in_length_2-1:0] COL_LAST = in_length_2'(in_length - 1);
  localparam logic [in_height_2-1:0] ROW_LAST = in_height_2'(in_height - 1);

  // Lanewise signed maximum; no width growth, ties are indistinguishable.
  function automatic logic [BUS_W-1:0] lane_max(input logic [BUS_W-1:0] a,
                                                input logic [BUS_W-1:0] b);
    logic [BUS_W-1:0]       r;
    logic signed [bits-1:0] la;
    logic signed [bits-1:0] lb;
    r = '0;
    for (int k = 0; k < channel_num; k++) begin
      la = a[k*bits +: bits];
      lb = b[k*bits +: bits];
      r[k*bits +: bits] = (la > lb) ? la : lb;
    end
    return r;
  endfunction

  logic [in_length_2-1:0]  col_q, col_d;
  logic [in_height_2-1:0]  row_q, row_d;
  logic [BUS_W-1:0]        pair_q, pair_d;
  logic [BUS_W-1:0]        line_q [out_length];
  logic [BUS_W-1:0]        data_out_q, data_out_d;
  logic                    start_q, start_d;
  logic                    frame_done_q, frame_done_d;

  logic                    col_last;
  logic                    row_last;
  logic [out_length_2-1:0] line_idx;
  logic                    line_we;
  logic [BUS_W-1:0]        line_wdata;

  assign col_last   = (col_q == COL_LAST);
  assign row_last   = (row_q == ROW_LAST);
  assign line_idx   = out_length_2'(col_q >> 1);
  // Max of the pair (even-column pixel) and the current odd-column pixel.
  assign line_wdata = lane_max(pair_q, data_in);

  // Next-state: raster counters, pair/line capture and window completion.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    pair_d       = pair_q;
    line_we      = 1'b0;
    data_out_d   = data_out_q;
    start_d      = 1'b0;
    frame_done_d = 1'b0;
    if (data_valid) begin
      if (!col_q[0]) begin
        pair_d = data_in;
      end else if (!row_q[0]) begin
        line_we = 1'b1;
      end else begin
        data_out_d   = lane_max(line_q[line_idx], line_wdata);
        start_d      = 1'b1;
        frame_done_d = row_last && col_last;
      end
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // State, output and line registers with asynchronous clear.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      pair_q       <= '0;
      data_out_q   <= '0;
      start_q      <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < out_length; i++) begin
        line_q[i] <= '0;
      end
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      pair_q       <= pair_d;
      data_out_q   <= data_out_d;
      start_q      <= start_d;
      frame_done_q <= frame_done_d;
      if (line_we) begin
        line_q[line_idx] <= line_wdata;
      end
    end
  end

  assign data_out   = data_out_q;
  assign start      = start_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pool2_maxpool.sv
// Self-checking bench for pool2_maxpool: a 4x2 directed instance plus a
// default-size instance driven with random frames and compared against a
// window-by-window reference model.
module tb_pool2_maxpool;

  localparam int W  = 128;
  localparam int L  = 44;
  localparam int H  = 122;
  localparam int NW = (L / 2) * (H / 2);

  logic clk = 1'b0;
  logic rst_n;

  logic          valid;
  logic [W-1:0]  din;
  logic [W-1:0]  dout;
  logic          start;
  logic          fdone;

  logic          s_valid;
  logic [W-1:0]  s_din;
  logic [W-1:0]  s_dout;
  logic          s_start;
  logic          s_fdone;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] frm [2][H][L];
  logic [W-1:0] exp_q [$];
  bit           exp_fd [$];
  logic [W-1:0] obs_q [$];
  bit           obs_fd [$];

  int  adj_cnt   = 0;
  int  stall_cnt = 0;
  int  stray_fd  = 0;
  bit  prev_start = 1'b0;
  bit  prev_v     = 1'b0;

  always #5 clk = ~clk;

  pool2_maxpool dut (
    .clk_in     (clk),
    .rst_n      (rst_n),
    .data_valid (valid),
    .data_in    (din),
    .data_out   (dout),
    .start      (start),
    .frame_done (fdone)
  );

  pool2_maxpool #(
    .bits(16), .bits_shift(4), .channel_num(8),
    .in_length(4), .in_length_2(2), .in_height(2), .in_height_2(1),
    .out_length(2), .out_length_2(1)
  ) dut_s (
    .clk_in     (clk),
    .rst_n      (rst_n),
    .data_valid (s_valid),
    .data_in    (s_din),
    .data_out   (s_dout),
    .start      (s_start),
    .frame_done (s_fdone)
  );

  // Pulse monitor for the default-size instance.
  always @(negedge clk) begin
    if (start) begin
      obs_q.push_back(dout);
      obs_fd.push_back(fdone);
      if (prev_start) adj_cnt <= adj_cnt + 1;
      if (!prev_v) stall_cnt <= stall_cnt + 1;
    end else if (fdone) begin
      stray_fd <= stray_fd + 1;
    end
    prev_start <= start;
    prev_v     <= valid;
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic gen_frame(input int f);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < L; c++)
        frm[f][r][c] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Reference: each output is the per-lane signed max of its 2x2 window.
  task automatic build_exp(input int f);
    logic [W-1:0] m;
    int v, best;
    for (int wr = 0; wr < H / 2; wr++) begin
      for (int wc = 0; wc < L / 2; wc++) begin
        m = '0;
        for (int k = 0; k < 8; k++) begin
          best = -65536;
          for (int d = 0; d < 4; d++) begin
            v = int'($signed(frm[f][2*wr + d/2][2*wc + d%2][16*k +: 16]));
            if (v > best) best = v;
          end
          m[16*k +: 16] = best[15:0];
        end
        exp_q.push_back(m);
        exp_fd.push_back((wr == H/2 - 1) && (wc == L/2 - 1));
      end
    end
  endtask

  // Drive frame f in raster order; stop_after >= 0 ends after that pixel index.
  task automatic drive_frame(input int f, input int stall_pct, input int stop_after);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < L; c++) begin
        while ($urandom_range(0, 99) < stall_pct) begin
          valid = 1'b0;
          din   = {$urandom, $urandom, $urandom, $urandom};
          @(posedge clk); #1;
        end
        valid = 1'b1;
        din   = frm[f][r][c];
        @(posedge clk); #1;
        if (stop_after >= 0 && r * L + c == stop_after) return;
      end
    end
  endtask

  task automatic cmp_run(input string tag);
    int n;
    check({tag, "_count"}, W'(obs_q.size()), W'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_data"}, obs_q[i], exp_q[i]);
      check({tag, "_fd"}, W'(obs_fd[i]), W'(exp_fd[i]));
    end
    check({tag, "_adjacent"}, W'(adj_cnt), W'(0));
    check({tag, "_stall_start"}, W'(stall_cnt), W'(0));
    check({tag, "_stray_fd"}, W'(stray_fd), W'(0));
    obs_q.delete(); obs_fd.delete(); exp_q.delete(); exp_fd.delete();
  endtask

  logic [W-1:0] sgn_exp;
  logic [W-1:0] s_exp;
  int           s_px [8];

  initial begin
    rst_n   = 1'b0;
    valid   = 1'b0;
    din     = '0;
    s_valid = 1'b0;
    s_din   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_dout", dout, '0);
    check("reset_start", W'(start), W'(0));
    check("reset_fd", W'(fdone), W'(0));
    check("reset_s_dout", s_dout, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed 4x2 frame on the small instance.
    s_px = '{1, 5, -3, 2, 4, 0, 7, -8};
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1;
      s_din   = '0;
      s_din[15:0] = s_px[i][15:0];
      @(posedge clk); #1;
      check("small_start", W'(s_start), W'((i == 5) || (i == 7)));
      check("small_fd", W'(s_fdone), W'(i == 7));
      s_exp = '0;
      if (i == 5 || i == 6) s_exp[15:0] = 16'd5;
      if (i == 7) s_exp[15:0] = 16'd7;
      if (i >= 5) check("small_dout", s_dout, s_exp);
    end
    s_valid = 1'b0;
    @(posedge clk); #1;
    check("small_start_drop", W'(s_start), W'(0));

    // Full default frame with a directed signed window at (0,0).
    gen_frame(0);
    for (int k = 0; k < 7; k++) begin
      frm[0][0][0][16*k +: 16] = -16'sd100;
      frm[0][0][1][16*k +: 16] = -16'sd2;
      frm[0][1][0][16*k +: 16] = -16'sd50;
      frm[0][1][1][16*k +: 16] = -16'sd7;
    end
    frm[0][0][0][127:112] = 16'h7FFF;
    frm[0][0][1][127:112] = 16'h8000;
    frm[0][1][0][127:112] = 16'h0000;
    frm[0][1][1][127:112] = 16'h0001;
    build_exp(0);
    drive_frame(0, 0, -1);
    valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sgn_exp = {16'h7FFF, {7{16'hFFFE}}};
    check("signed_window", (obs_q.size() > 0) ? obs_q[0] : '0, sgn_exp);
    cmp_run("frame_cont");

    // Same frame with 50% stalls.
    build_exp(0);
    drive_frame(0, 50, -1);
    valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cmp_run("frame_stall");

    // Reset after pixel (3,17).
    gen_frame(1);
    build_exp(1);
    drive_frame(1, 0, 3 * L + 17);
    check("pre_reset_count", W'(obs_q.size()), W'(30));
    check("pre_reset_start", W'(start), W'(1));
    check("pre_reset_dout", dout, exp_q[30]);
    if (obs_q.size() >= 30) check("pre_reset_last", obs_q[29], exp_q[29]);
    rst_n = 1'b0;
    valid = 1'b0;
    #1;
    check("async_dout", dout, '0);
    check("async_start", W'(start), W'(0));
    check("async_fd", W'(fdone), W'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    obs_q.delete(); obs_fd.delete(); exp_q.delete(); exp_fd.delete();
    @(posedge clk); #1;
    gen_frame(0);
    build_exp(0);
    drive_frame(0, 0, -1);
    valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cmp_run("after_reset");

    // Two frames back to back, no idle cycle.
    gen_frame(0);
    gen_frame(1);
    build_exp(0);
    build_exp(1);
    drive_frame(0, 0, -1);
    drive_frame(1, 0, -1);
    valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cmp_run("back_to_back");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pool2_maxpool.md
Name: pool2_maxpool

Overview:
- 2x2, stride-2 max-pooling stage for layer 2.
- Consumes the conv2 feature-map stream: 8 channels x 16-bit signed per pixel, raster order.
- Emits one pooled pixel per 2x2 window, with a single-cycle start pulse, directly into pool2_out_buffer (data_in/start).
- Holds one half-width line of partial maxima in registers; no block RAM.

Parameters:
- bits, 16: quantization width of one channel value (signed two's complement)
- bits_shift, 4: log2(bits); bus width is channel_num<<bits_shift
- channel_num, 8: channels per pixel
- in_length, 44: input columns (even)
- in_length_2, 6: counter width for in_length
- in_height, 122: input rows (even)
- in_height_2, 7: counter width for in_height
- out_length, 22: in_length/2, depth of the line register array
- out_length_2, 5: index width for out_length

Ports:
- clk_in  input  1  clock; all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- data_valid  input  1  data_in valid this cycle; at most one pixel per cycle
- data_in  input  channel_num<<bits_shift  conv2 pixel; lane k = bits [16k+15:16k]
- data_out  output  channel_num<<bits_shift  pooled pixel, registered, held between pulses
- start  output  1  one-cycle pulse: data_out carries a new pooled pixel
- frame_done  output  1  one-cycle pulse coincident with start of the last pooled pixel in a frame

Behaviour:
- Reset (rst_n low, async): data_out=0, start=0, frame_done=0, col=0, row=0, pair register=0, line registers=0.
- All operations below apply only in cycles with data_valid=1; otherwise counters and storage hold, and start/frame_done are 0.
- Counters: col runs 0..in_length-1; on col=in_length-1 it wraps to 0 and row increments. On row=in_height-1 and col=in_length-1, both wrap to 0 (next frame). No idle or restart state.
- Max is per 16-bit lane, signed compare; ties select either value (identical). No rounding or width growth.
- Even col: pair <= data_in.
- Odd col, even row: line[col>>1] <= lanewise max(pair, data_in).
- Odd col, odd row:
  - data_out <= lanewise max(line[col>>1], pair, data_in);
  - start <= 1 for the following cycle only.
- Latency: data_out/start are valid 1 cycle after the accepted 4th pixel of a window (odd row, odd col).
- Start spacing: pulses occur only on odd columns, so rising edges are at least 2 cycles apart. start drops to 0 between consecutive pulses, which pool2_out_buffer needs for edge detection.
- frame_done=1 in the same cycle as start when the window is (row=in_height-1, col=in_length-1).
- Output count per frame: out_length*(in_height/2) pulses (22*61=1342 at defaults).
- Back-to-back frames: the first pixel of the next frame may arrive the cycle after the last pixel of the previous one. Line contents need not be cleared; every entry is overwritten on each even row before it is read.
- Reset mid-frame: all counters return to 0; the next valid pixel is treated as (row 0, col 0). Any partial window is discarded and no start is emitted for it.
- Gaps in data_valid of any length inside a row or window: no effect on the result.

Test Plan:
- Single 4x2 frame (in_length=4, in_height=2).
  - Stimulus: lane0 values row0 = {1,5,-3,2}, row1 = {4,0,7,-8}; data_valid continuous.
  - Required: two start pulses, 1 cycle after pixels (1,1) and (1,3).
  - Required: data_out lane0 = 5, then 7; frame_done only on the second pulse.
- Signed compare, default size.
  - Stimulus: window lanes all negative {-100,-2,-50,-7}; lane7 = {0x7FFF,0x8000,0,1}.
  - Required: lane = -2 (0xFFFE); lane7 = 0x7FFF.
- Full default frame, 44x122 random values, continuous valid.
  - Required: exactly 1342 start pulses, each matching the reference model.
  - Required: no two pulses in adjacent cycles; one frame_done, on pulse 1342.
- Stalls: same frame as previous scenario with data_valid randomly low 50% of cycles.
  - Required: identical data_out sequence; start never asserted in a cycle following data_valid=0.
- Reset mid-frame: assert rst_n=0 after pixel (row 3, col 17).
  - Required: outputs read 0 immediately (asynchronously).
  - Required: after release, a fresh 44x122 frame gives 1342 correct pulses with no stale window.
- Back-to-back frames: two full default frames with no idle cycle between them.
  - Required: 2684 pulses; the first window of frame 2 is unaffected by frame 1 line contents.
